// File: rtl/mem_resp_pkg.sv
// Shared constants and FSM state encoding for the main-memory line responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_resp_pkg;

    localparam int WORD_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int LINE_WORDS  = 16;
    localparam int LINE_ADDR_W = 12;
    localparam int OFFSET_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        WR_WAIT,
        WR_DONE
    } state_t;

endpackage

// File: rtl/mem_line_responder_if.sv
// Cache-to-memory line refill/writeback bundle: request, write-beat and read-beat channels.
// Latency: none, wires only.
// Backpressure: req_ready, wdata_ready (responder) and rdata_ready (cache) gate each channel.
// Ports: master = cache side (drives requests, write beats, read ready);
//        slave  = memory side (drives req_ready, wdata_ready, read beats, wr_done).
interface mem_line_responder_if;
    import mem_resp_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [LINE_ADDR_W-1:0] req_line;

    logic                   wdata_valid;
    logic [WORD_W-1:0]      wdata;
    logic                   wdata_ready;

    logic                   rdata_valid;
    logic [WORD_W-1:0]      rdata;
    logic                   rdata_last;
    logic                   rdata_ready;

    logic                   wr_done;

    modport master (
        output req_valid, req_we, req_line, wdata_valid, wdata, rdata_ready,
        input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wr_done
    );

    modport slave (
        input  req_valid, req_we, req_line, wdata_valid, wdata, rdata_ready,
        output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wr_done
    );

endinterface

// File: rtl/mem_word_array.sv
// 64K x 16 backing store with one synchronous write port and one asynchronous read port.
// Latency: write lands at the clock edge; read data follows raddr combinationally.
// Backpressure: none, accepts a write every cycle.
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port.
module mem_word_array
    import mem_resp_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    // Power-up image; reset never touches the array contents.
    logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1] = '{
        0:       WORD_W'(1500),
        1:       WORD_W'(1020),
        16:      WORD_W'(156),
        128:     WORD_W'(32),
        default: '0
    };

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_line_responder.sv
// Main-memory responder serving whole 16-word line reads (refill) and line writes (writeback).
// Latency: first read beat ACCESS_LAT cycles after accept; wr_done ACCESS_LAT+1 cycles after beat 15 is written.
// Backpressure: one request at a time (req_ready only in IDLE); read beats hold while rdata_ready is low.
// Ports: clk, rst_n (synchronous, active low), bus (slave side of mem_line_responder_if).
module mem_line_responder
    import mem_resp_pkg::*;
#(
    parameter int ACCESS_LAT = 4
)(
    input  logic                 clk,
    input  logic                 rst_n,
    mem_line_responder_if.slave  bus
);

    localparam logic [3:0]          LAT_LOAD = 4'(ACCESS_LAT - 1);
    localparam logic [OFFSET_W-1:0] LAST_IDX = OFFSET_W'(LINE_WORDS - 1);

    state_t                 state_q, state_d;
    logic [LINE_ADDR_W-1:0] line_q, line_d;
    logic [OFFSET_W-1:0]    idx_q, idx_d;
    logic [3:0]             cnt_q, cnt_d;

    logic                   req_rdy, wr_rdy, rd_vld, rd_last, done;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [WORD_W-1:0]      mem_rdata;

    assign mem_addr = {line_q, idx_q};

    mem_word_array u_array (
        .clk   (clk),
        .we    (mem_we & rst_n),
        .waddr (mem_addr),
        .wdata (bus.wdata),
        .raddr (mem_addr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            line_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        req_rdy = 1'b0;
        wr_rdy  = 1'b0;
        rd_vld  = 1'b0;
        rd_last = 1'b0;
        done    = 1'b0;
        mem_we  = 1'b0;

        case (state_q)
            IDLE: begin
                req_rdy = 1'b1;
                if (bus.req_valid) begin
                    line_d = bus.req_line;
                    idx_d  = '0;
                    cnt_d  = LAT_LOAD;
                    if (bus.req_we) begin
                        state_d = WR_BURST;
                    end else if (LAT_LOAD == 4'd0) begin
                        state_d = RD_BURST;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end

            // The counter reaches zero on the same edge that enters RD_BURST,
            // so the wait lasts exactly ACCESS_LAT-1 cycles.
            RD_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 4'd1) begin
                    state_d = RD_BURST;
                end
            end

            RD_BURST: begin
                rd_vld  = 1'b1;
                rd_last = (idx_q == LAST_IDX);
                if (bus.rdata_ready) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end
                end
            end

            WR_BURST: begin
                wr_rdy = 1'b1;
                if (bus.wdata_valid) begin
                    mem_we = 1'b1;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        cnt_d   = LAT_LOAD;
                        state_d = WR_WAIT;
                    end
                end
            end

            // Counter is tested before decrement here: ACCESS_LAT wait cycles.
            WR_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = WR_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            WR_DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset is synchronous, so outputs are masked by rst_n to read as
    // idle/zero for the whole time reset is held, not just after the edge.
    assign bus.req_ready   = rst_n & req_rdy;
    assign bus.wdata_ready = rst_n & wr_rdy;
    assign bus.rdata_valid = rst_n & rd_vld;
    assign bus.rdata_last  = rst_n & rd_last;
    assign bus.rdata       = (rst_n & rd_vld) ? mem_rdata : '0;
    assign bus.wr_done     = rst_n & done;

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: reset, reads, gapped write, stall, busy, mid-write reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_line_responder;
    import mem_resp_pkg::*;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_line_responder_if bus();

    mem_line_responder #(.ACCESS_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] rd_data [16];
    logic [15:0] rd_last_vec;
    int          rd_first, rd_vld_cycles, rd_beats;
    logic        rd_timeout;
    logic [15:0] st_data [4];
    logic        st_vld [4];
    int          st_n, inj_rdy_seen;
    logic        wr_first_rdy, wr_timeout, rdy_after;
    int          done_at, done_cnt;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic read_line(input logic [11:0] line, input int stall_beat,
                             input int stall_n, input bit inject);
        int cyc;
        int left;
        bus.rdata_ready = 1'b1;
        bus.req_we      = 1'b0;
        bus.req_line    = line;
        bus.req_valid   = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        cyc = 1; left = stall_n; rd_beats = 0; rd_first = -1; rd_vld_cycles = 0;
        rd_last_vec = '0; st_n = 0; inj_rdy_seen = 0; rd_timeout = 1'b0;
        while (rd_beats < 16) begin
            if (cyc > 200) begin
                rd_timeout = 1'b1;
                break;
            end
            if (inject && rd_beats >= 3) begin
                bus.req_valid = 1'b1;
                bus.req_we    = 1'b1;
                bus.req_line  = 12'h0FF;
                if (bus.req_ready) inj_rdy_seen++;
            end
            if (rd_beats == stall_beat && left > 0) begin
                bus.rdata_ready = 1'b0;
                left--;
                if (st_n < 4) begin
                    st_data[st_n] = bus.rdata;
                    st_vld[st_n]  = bus.rdata_valid;
                    st_n++;
                end
            end else begin
                bus.rdata_ready = 1'b1;
            end
            if (bus.rdata_valid) begin
                rd_vld_cycles++;
                if (rd_first < 0) rd_first = cyc;
            end
            if (bus.rdata_valid && bus.rdata_ready) begin
                rd_data[rd_beats[3:0]]     = bus.rdata;
                rd_last_vec[rd_beats[3:0]] = bus.rdata_last;
                rd_beats++;
            end
            tick();
            cyc++;
        end
        bus.rdata_ready = 1'b1;
    endtask

    task automatic write_start(input logic [11:0] line);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_line  = line;
        tick();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        wr_first_rdy  = bus.wdata_ready;
    endtask

    task automatic write_beats(input logic [15:0] base, input bit incr, input int nbeats,
                               input int gap_after, input int gap_n);
        int i;
        int g;
        int cyc;
        i = 0; g = 0; cyc = 0; wr_timeout = 1'b0;
        while (i < nbeats) begin
            if (cyc > 100) begin
                wr_timeout = 1'b1;
                break;
            end
            if (i == gap_after && g < gap_n) begin
                bus.wdata_valid = 1'b0;
                g++;
            end else begin
                bus.wdata_valid = 1'b1;
                bus.wdata       = incr ? base + 16'(i) : base;
                if (bus.wdata_ready) i++;
            end
            tick();
            cyc++;
        end
        bus.wdata_valid = 1'b0;
    endtask

    // k counts falling edges after the edge that wrote the last beat (k=1 first).
    task automatic wait_done(input int window);
        done_at = -1; done_cnt = 0; rdy_after = 1'b0;
        for (int k = 1; k <= window; k++) begin
            if (bus.wr_done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (done_at > 0 && k == done_at + 1) rdy_after = bus.req_ready;
            if (k < window) tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready);
        end
        checks++;
        if ({bus.wdata_ready, bus.rdata_valid, bus.rdata_last, bus.wr_done, bus.rdata} !== 20'h0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0",
                {bus.wdata_ready, bus.rdata_valid, bus.rdata_last, bus.wr_done, bus.rdata});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_req_ready: got %b expected 1", bus.req_ready);
        end
        checks++;
        if ({bus.wdata_ready, bus.rdata_valid, bus.rdata_last, bus.wr_done, bus.rdata} !== 20'h0) begin
            errors++; $display("FAIL post_reset_outputs: got %h expected 0",
                {bus.wdata_ready, bus.rdata_valid, bus.rdata_last, bus.wr_done, bus.rdata});
        end
    endtask

    task automatic test_read_basic();
        logic [15:0] exp;
        read_line(12'h000, -1, 0, 1'b0);
        checks++;
        if (rd_timeout !== 1'b0 || rd_beats != 16) begin
            errors++; $display("FAIL rd0_beats: got %0d beats timeout %b expected 16 beats", rd_beats, rd_timeout);
        end
        checks++;
        if (rd_first != LAT) begin
            errors++; $display("FAIL rd0_latency: got %0d expected %0d", rd_first, LAT);
        end
        checks++;
        if (rd_vld_cycles != 16) begin
            errors++; $display("FAIL rd0_burst_len: got %0d expected 16", rd_vld_cycles);
        end
        for (int i = 0; i < 16; i++) begin
            exp = (i == 0) ? 16'd1500 : (i == 1) ? 16'd1020 : 16'd0;
            checks++;
            if (rd_data[i] !== exp) begin
                errors++; $display("FAIL rd0_data[%0d]: got %0d expected %0d", i, rd_data[i], exp);
            end
        end
        checks++;
        if (rd_last_vec !== 16'h8000) begin
            errors++; $display("FAIL rd0_last: got %h expected 8000", rd_last_vec);
        end
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rdata_valid !== 1'b0) begin
            errors++; $display("FAIL rd0_idle_after: got rdy %b vld %b expected 1 0", bus.req_ready, bus.rdata_valid);
        end
    endtask

    task automatic test_read_preload();
        logic [15:0] exp;
        read_line(12'h001, -1, 0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            exp = (i == 0) ? 16'd156 : 16'd0;
            checks++;
            if (rd_data[i] !== exp) begin
                errors++; $display("FAIL rd1_data[%0d]: got %0d expected %0d", i, rd_data[i], exp);
            end
        end
        read_line(12'h008, -1, 0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            exp = (i == 0) ? 16'd32 : 16'd0;
            checks++;
            if (rd_data[i] !== exp) begin
                errors++; $display("FAIL rd8_data[%0d]: got %0d expected %0d", i, rd_data[i], exp);
            end
        end
    endtask

    task automatic test_write_gap();
        write_start(12'h123);
        checks++;
        if (wr_first_rdy !== 1'b1) begin
            errors++; $display("FAIL wr_ready_first: got %b expected 1", wr_first_rdy);
        end
        write_beats(16'h1000, 1'b1, 16, 6, 2);
        checks++;
        if (wr_timeout !== 1'b0) begin
            errors++; $display("FAIL wr_beats_timeout: got %b expected 0", wr_timeout);
        end
        wait_done(8);
        checks++;
        if (done_at != LAT + 1) begin
            errors++; $display("FAIL wr_done_time: got %0d expected %0d", done_at, LAT + 1);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL wr_done_count: got %0d expected 1", done_cnt);
        end
        checks++;
        if (rdy_after !== 1'b1) begin
            errors++; $display("FAIL wr_ready_after_done: got %b expected 1", rdy_after);
        end
        read_line(12'h123, -1, 0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rd_data[i] !== 16'h1000 + 16'(i)) begin
                errors++; $display("FAIL wr123_readback[%0d]: got %h expected %h", i, rd_data[i], 16'h1000 + 16'(i));
            end
        end
    endtask

    task automatic test_read_stall();
        logic [15:0] exp;
        read_line(12'h000, 5, 3, 1'b0);
        checks++;
        if (rd_timeout !== 1'b0 || rd_beats != 16) begin
            errors++; $display("FAIL stall_beats: got %0d beats timeout %b expected 16", rd_beats, rd_timeout);
        end
        checks++;
        if (rd_vld_cycles != 19) begin
            errors++; $display("FAIL stall_valid_cycles: got %0d expected 19", rd_vld_cycles);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (st_vld[k] !== 1'b1 || st_data[k] !== 16'd0) begin
                errors++; $display("FAIL stall_hold[%0d]: got vld %b data %0d expected 1 0", k, st_vld[k], st_data[k]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            exp = (i == 0) ? 16'd1500 : (i == 1) ? 16'd1020 : 16'd0;
            checks++;
            if (rd_data[i] !== exp) begin
                errors++; $display("FAIL stall_data[%0d]: got %0d expected %0d", i, rd_data[i], exp);
            end
        end
        checks++;
        if (rd_last_vec !== 16'h8000) begin
            errors++; $display("FAIL stall_last: got %h expected 8000", rd_last_vec);
        end
    endtask

    task automatic test_busy_ignore();
        read_line(12'h008, -1, 0, 1'b1);
        checks++;
        if (inj_rdy_seen != 0) begin
            errors++; $display("FAIL busy_req_ready: got %0d ready cycles expected 0", inj_rdy_seen);
        end
        checks++;
        if (rd_beats != 16 || rd_data[0] !== 16'd32 || rd_data[15] !== 16'd0) begin
            errors++; $display("FAIL busy_read_data: got %0d beats word0 %0d expected 16 32", rd_beats, rd_data[0]);
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL busy_ready_after: got %b expected 1", bus.req_ready);
        end
        tick();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        checks++;
        if (bus.wdata_ready !== 1'b1 || bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL busy_accepted: got wrdy %b rrdy %b expected 1 0", bus.wdata_ready, bus.req_ready);
        end
        write_beats(16'h5000, 1'b1, 16, -1, 0);
        wait_done(8);
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL busy_wr_done: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [15:0] exp;
        write_start(12'h000);
        write_beats(16'hAAAA, 1'b0, 7, -1, 0);
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus.wdata_ready !== 1'b0 || bus.wr_done !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: got wrdy %b done %b expected 0 0", bus.wdata_ready, bus.wr_done);
        end
        tick();
        rst_n = 1'b1;
        tick();
        wait_done(10);
        checks++;
        if (done_cnt != 0) begin
            errors++; $display("FAIL midrst_no_done: got %0d expected 0", done_cnt);
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_idle: got %b expected 1", bus.req_ready);
        end
        read_line(12'h000, -1, 0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            exp = (i < 7) ? 16'hAAAA : 16'h0000;
            checks++;
            if (rd_data[i] !== exp) begin
                errors++; $display("FAIL midrst_data[%0d]: got %h expected %h", i, rd_data[i], exp);
            end
        end
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_we      = 1'b0;
        bus.req_line    = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        bus.rdata_ready = 1'b1;
        test_reset();
        test_read_basic();
        test_read_preload();
        test_write_gap();
        test_read_stall();
        test_busy_ignore();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
